// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: trigger-level encodings,
// the timeout FSM state type and the per-character FIFO entry.
package uart_pkg;

    localparam logic [1:0] TRIG_1  = 2'b00;
    localparam logic [1:0] TRIG_4  = 2'b01;
    localparam logic [1:0] TRIG_8  = 2'b10;
    localparam logic [1:0] TRIG_14 = 2'b11;

    typedef enum logic [1:0] {
        TO_EMPTY,
        TO_WAIT,
        TO_TOUT
    } tout_state_e;

    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    function automatic int unsigned trig_count(input logic [1:0] lvl);
        int unsigned cnt;
        case (lvl)
            TRIG_1:  cnt = 1;
            TRIG_4:  cnt = 4;
            TRIG_8:  cnt = 8;
            default: cnt = 14;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible on rd_data.
// A simultaneous write and read while full is accepted (the head leaves as the new word lands).
module uart_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign rd_ok = rd_en && (count != '0);
    assign wr_ok = wr_en && ((count != FULL_CNT) || rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; consumers gate rd_data with count.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive FIFO controller: capacity/overrun policy, error tracking, character timeout
// and the registered receive interrupt around a FWFT storage FIFO.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int TOUT_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_pulse,
    input  logic                     fifo_en,
    input  logic                     fifo_clr,
    input  logic [1:0]               trig_lvl,
    input  logic                     rx_push,
    input  logic [7:0]               rx_data,
    input  logic                     rx_pe,
    input  logic                     rx_fe,
    input  logic                     rx_bi,
    input  logic                     rd,
    input  logic                     lsr_rd,
    output logic [7:0]               rd_data,
    output logic                     head_pe,
    output logic                     head_fe,
    output logic                     head_bi,
    output logic                     dr,
    output logic                     oe,
    output logic                     fifo_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rx_irq,
    output logic                     tout
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(TOUT_TICKS + 1);

    tout_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] err_cnt;
    logic [LW-1:0] cap;
    logic [LW-1:0] lvl_nxt;
    logic [LW-1:0] trig;
    rx_entry_t     wr_entry;
    rx_entry_t     head;
    logic          fifo_en_q;
    logic          clr;
    logic          full;
    logic          rd_ok;
    logic          overrun;
    logic          overwrite;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          irq_d;

    // A mode change flushes the FIFO exactly like an explicit clear.
    assign clr       = fifo_clr || (fifo_en != fifo_en_q);
    assign cap       = fifo_en ? LW'(DEPTH) : LW'(1);
    assign full      = (level == cap);
    assign rd_ok     = !clr && rd && (level != '0);
    assign overrun   = !clr && rx_push && full && !rd_ok;
    assign overwrite = overrun && !fifo_en;
    assign fifo_wr   = !clr && rx_push && (!full || rd_ok || !fifo_en);
    assign fifo_rd   = rd_ok || overwrite;
    assign trig      = LW'(trig_count(trig_lvl));
    assign wr_entry  = '{bi: rx_bi, fe: rx_fe, pe: rx_pe, data: rx_data};

    uart_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .count   (level)
    );

    always_comb begin
        lvl_nxt = level;
        if (clr) begin
            lvl_nxt = '0;
        end else begin
            case ({fifo_wr, fifo_rd})
                2'b10:   lvl_nxt = level + 1'b1;
                2'b01:   lvl_nxt = level - 1'b1;
                default: lvl_nxt = level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_en_q <= 1'b1;
            oe        <= 1'b0;
            err_cnt   <= '0;
        end else begin
            fifo_en_q <= fifo_en;
            if (overrun)     oe <= 1'b1;
            else if (lsr_rd) oe <= 1'b0;
            if (clr) begin
                err_cnt <= '0;
            end else begin
                case ({fifo_wr && (rx_pe || rx_fe || rx_bi),
                       fifo_rd && (head.pe || head.fe || head.bi)})
                    2'b10:   err_cnt <= err_cnt + 1'b1;
                    2'b01:   err_cnt <= err_cnt - 1'b1;
                    default: err_cnt <= err_cnt;
                endcase
            end
        end
    end

    // Any character arrival or accepted read restarts the idle count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!fifo_en || lvl_nxt == '0) begin
            state_d = TO_EMPTY;
            cnt_d   = '0;
        end else if (rx_push || fifo_rd || state_q == TO_EMPTY) begin
            state_d = TO_WAIT;
            cnt_d   = '0;
        end else if (state_q == TO_WAIT && baud_pulse) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(TOUT_TICKS)) state_d = TO_TOUT;
        end
    end

    always_comb begin
        irq_d = 1'b0;
        if (fifo_en) irq_d = (lvl_nxt >= trig) || (state_d == TO_TOUT);
        else         irq_d = (lvl_nxt != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TO_EMPTY;
            cnt_q   <= '0;
            rx_irq  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_irq  <= irq_d;
        end
    end

    assign dr       = (level != '0);
    assign rd_data  = dr ? head.data : 8'h00;
    assign head_pe  = dr && head.pe;
    assign head_fe  = dr && head.fe;
    assign head_bi  = dr && head.bi;
    assign fifo_err = (err_cnt != '0);
    assign tout     = (state_q == TO_TOUT);

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: each task drives one scenario and checks
// hand-computed expectations one time unit after the rising clock edge.
module tb_uart_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse, fifo_en, fifo_clr, rx_push, rx_pe, rx_fe, rx_bi, rd, lsr_rd;
    logic [1:0] trig_lvl;
    logic [7:0] rx_data;
    logic [7:0] rd_data;
    logic       head_pe, head_fe, head_bi, dr, oe, fifo_err, rx_irq, tout;
    logic [4:0] level;

    int vectors     = 0;
    int miscompares = 0;

    uart_rx_fifo_ctrl #(.DEPTH(16), .TOUT_TICKS(640)) dut (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
        .trig_lvl(trig_lvl), .rx_push(rx_push), .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe),
        .rx_bi(rx_bi), .rd(rd), .lsr_rd(lsr_rd), .rd_data(rd_data), .head_pe(head_pe),
        .head_fe(head_fe), .head_bi(head_bi), .dr(dr), .oe(oe), .fifo_err(fifo_err),
        .level(level), .rx_irq(rx_irq), .tout(tout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [2:0] err);
        rx_data = d;
        {rx_bi, rx_fe, rx_pe} = err;
        rx_push = 1'b1;
        step();
        rx_push = 1'b0;
        {rx_bi, rx_fe, rx_pe} = 3'b000;
    endtask

    task automatic pop();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        vectors++; if (dr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dr: got %b expected 0", dr); end
        vectors++; if (oe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_oe: got %b expected 0", oe); end
        vectors++; if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq: got %b expected 0", rx_irq); end
        vectors++; if (tout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tout: got %b expected 0", tout); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
        vectors++; if (fifo_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fifo_err: got %b expected 0", fifo_err); end
    endtask

    task automatic test_trigger();
        trig_lvl = 2'b01;
        push_byte(8'h41, 3'b000);
        push_byte(8'h42, 3'b000);
        push_byte(8'h43, 3'b000);
        vectors++; if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL trig_irq_3: got %b expected 0", rx_irq); end
        push_byte(8'h44, 3'b000);
        vectors++; if (rx_irq !== 1'b1) begin miscompares++; $display("[TB] FAIL trig_irq_4: got %b expected 1", rx_irq); end
        vectors++; if (level !== 5'd4) begin miscompares++; $display("[TB] FAIL trig_level: got %0d expected 4", level); end
        vectors++; if (rd_data !== 8'h41) begin miscompares++; $display("[TB] FAIL trig_head: got %h expected 41", rd_data); end
        pop();
        vectors++; if (rd_data !== 8'h42) begin miscompares++; $display("[TB] FAIL trig_next: got %h expected 42", rd_data); end
        vectors++; if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL trig_irq_drop: got %b expected 0", rx_irq); end
        pop();
        pop();
        vectors++; if (rd_data !== 8'h44) begin miscompares++; $display("[TB] FAIL trig_last: got %h expected 44", rd_data); end
        pop();
        vectors++; if (dr !== 1'b0) begin miscompares++; $display("[TB] FAIL trig_drained: got %b expected 0", dr); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 3'b000);
        vectors++; if (level !== 5'd16) begin miscompares++; $display("[TB] FAIL ovr_full_level: got %0d expected 16", level); end
        vectors++; if (oe !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_oe_before: got %b expected 0", oe); end
        push_byte(8'h99, 3'b000);
        vectors++; if (level !== 5'd16) begin miscompares++; $display("[TB] FAIL ovr_level: got %0d expected 16", level); end
        vectors++; if (oe !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_oe_set: got %b expected 1", oe); end
        lsr_rd = 1'b1;
        push_byte(8'h9A, 3'b000);
        lsr_rd = 1'b0;
        vectors++; if (oe !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_set_wins: got %b expected 1", oe); end
        lsr_rd = 1'b1;
        step();
        lsr_rd = 1'b0;
        vectors++; if (oe !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_lsr_clear: got %b expected 0", oe); end
        vectors++; if (rd_data !== 8'h80) begin miscompares++; $display("[TB] FAIL ovr_head: got %h expected 80", rd_data); end
    endtask

    task automatic test_full_push_rd();
        logic [7:0] exp;
        rx_data = 8'h55;
        rx_push = 1'b1;
        rd = 1'b1;
        step();
        rx_push = 1'b0;
        rd = 1'b0;
        vectors++; if (level !== 5'd16) begin miscompares++; $display("[TB] FAIL fpr_level: got %0d expected 16", level); end
        vectors++; if (oe !== 1'b0) begin miscompares++; $display("[TB] FAIL fpr_oe: got %b expected 0", oe); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'h81 + 8'(i) : 8'h55;
            vectors++; if (rd_data !== exp) begin miscompares++; $display("[TB] FAIL fpr_order[%0d]: got %h expected %h", i, rd_data, exp); end
            pop();
        end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL fpr_drained: got %0d expected 0", level); end
    endtask

    task automatic test_timeout();
        trig_lvl = 2'b01;
        push_byte(8'h33, 3'b000);
        for (int i = 0; i < 639; i++) begin
            baud_pulse = 1'b1;
            step();
            baud_pulse = 1'b0;
            step();
        end
        vectors++; if (tout !== 1'b0) begin miscompares++; $display("[TB] FAIL tout_early: got %b expected 0", tout); end
        vectors++; if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL tout_irq_early: got %b expected 0", rx_irq); end
        baud_pulse = 1'b1;
        step();
        baud_pulse = 1'b0;
        vectors++; if (tout !== 1'b1) begin miscompares++; $display("[TB] FAIL tout_set: got %b expected 1", tout); end
        vectors++; if (rx_irq !== 1'b1) begin miscompares++; $display("[TB] FAIL tout_irq: got %b expected 1", rx_irq); end
        pop();
        vectors++; if (tout !== 1'b0) begin miscompares++; $display("[TB] FAIL tout_clear: got %b expected 0", tout); end
        vectors++; if (dr !== 1'b0) begin miscompares++; $display("[TB] FAIL tout_dr: got %b expected 0", dr); end
    endtask

    task automatic test_holding();
        fifo_en = 1'b0;
        step();
        push_byte(8'h10, 3'b000);
        vectors++; if (rx_irq !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_irq: got %b expected 1", rx_irq); end
        vectors++; if (oe !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_oe_before: got %b expected 0", oe); end
        push_byte(8'h20, 3'b000);
        vectors++; if (rd_data !== 8'h20) begin miscompares++; $display("[TB] FAIL hold_overwrite: got %h expected 20", rd_data); end
        vectors++; if (level !== 5'd1) begin miscompares++; $display("[TB] FAIL hold_level: got %0d expected 1", level); end
        vectors++; if (oe !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_oe: got %b expected 1", oe); end
        lsr_rd = 1'b1;
        pop();
        lsr_rd = 1'b0;
        vectors++; if (dr !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_pop: got %b expected 0", dr); end
        push_byte(8'h5A, 3'b010);
        vectors++; if (head_fe !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_head_fe: got %b expected 1", head_fe); end
        vectors++; if (fifo_err !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_fifo_err: got %b expected 1", fifo_err); end
        pop();
        vectors++; if (fifo_err !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_err_pop: got %b expected 0", fifo_err); end
        fifo_en = 1'b1;
        step();
    endtask

    task automatic test_clear_and_empty();
        pop();
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL empty_rd: got %0d expected 0", level); end
        rx_data = 8'h66;
        rx_push = 1'b1;
        rd = 1'b1;
        step();
        rx_push = 1'b0;
        rd = 1'b0;
        vectors++; if (level !== 5'd1) begin miscompares++; $display("[TB] FAIL empty_push_rd: got %0d expected 1", level); end
        vectors++; if (rd_data !== 8'h66) begin miscompares++; $display("[TB] FAIL empty_push_rd_data: got %h expected 66", rd_data); end
        push_byte(8'h67, 3'b001);
        vectors++; if (fifo_err !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_err_before: got %b expected 1", fifo_err); end
        rx_data = 8'h68;
        rx_push = 1'b1;
        fifo_clr = 1'b1;
        step();
        rx_push = 1'b0;
        fifo_clr = 1'b0;
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL clr_level: got %0d expected 0", level); end
        vectors++; if (fifo_err !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_fifo_err: got %b expected 0", fifo_err); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL clr_rd_data: got %h expected 00", rd_data); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i), 3'b000);
        vectors++; if (level !== 5'd5) begin miscompares++; $display("[TB] FAIL mid_level: got %0d expected 5", level); end
        vectors++; if (rx_irq !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_irq: got %b expected 1", rx_irq); end
        rx_data = 8'hEE;
        rx_push = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL mid_async_level: got %0d expected 0", level); end
        vectors++; if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async_irq: got %b expected 0", rx_irq); end
        vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_async_data: got %h expected 00", rd_data); end
        vectors++; if (dr !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async_dr: got %b expected 0", dr); end
        rx_push = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();
        vectors++; if (level !== 5'd0) begin miscompares++; $display("[TB] FAIL mid_after_level: got %0d expected 0", level); end
        vectors++; if (rx_irq !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_after_irq: got %b expected 0", rx_irq); end
    endtask

    initial begin
        rst = 1'b1;
        baud_pulse = 1'b0;
        fifo_en = 1'b1;
        fifo_clr = 1'b0;
        trig_lvl = 2'b01;
        rx_push = 1'b0;
        rx_data = 8'h00;
        {rx_bi, rx_fe, rx_pe} = 3'b000;
        rd = 1'b0;
        lsr_rd = 1'b0;
        repeat (2) step();
        test_reset();
        rst = 1'b0;
        step();
        test_trigger();
        test_overrun();
        test_full_push_rd();
        test_timeout();
        test_holding();
        test_clear_and_empty();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
